sfp_cage_ctrl: RTL and testbench

//  Per-cage SFP management for NUM_SFP optical ports on the PL side. Replaces hard-wired tx_disable/status nets.

---
 rtl/sfp_ctrl_pkg.sv | 21 ++
 rtl/sfp_debounce.sv | 39 +++
 rtl/sfp_cage_ctrl.sv | 148 ++++++++++++++
 tb/tb_sfp_cage_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sfp_ctrl_pkg.sv
// Shared types and width helpers for the SFP cage controller.
package sfp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_INIT     = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_LATCHED  = 3'd4
  } chan_state_e;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int timer_w(input int a, input int b);
    return cnt_w((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/sfp_debounce.sv
// One-bit 2-flop synchroniser followed by a stable-count filter.
module sfp_debounce
  import sfp_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 1024,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_w(DEBOUNCE_CYC);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Sync flops reset to RST_VAL so no count starts straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      dout <= RST_VAL;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sfp_cage_ctrl.sv
// Per-cage SFP enable/retry/latch control with merged irq and status LED.
module sfp_cage_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int NUM_SFP      = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int INIT_CYC     = 2**20,
  parameter int TXDIS_CYC    = 2000,
  parameter int MAX_RETRIES  = 3,
  parameter int LED_HALF_CYC = 2**24
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_SFP-1:0]     sfp_rx_loss,
  input  logic [NUM_SFP-1:0]     sfp_tx_fault,
  output logic [NUM_SFP-1:0]     sfp_tx_disable,
  input  logic [NUM_SFP-1:0]     enable,
  input  logic [NUM_SFP-1:0]     clear_fault,
  output logic [NUM_SFP-1:0]     link_up,
  output logic [NUM_SFP-1:0]     fault_latched,
  output logic [3*NUM_SFP-1:0]   chan_state,
  output logic                   irq,
  output logic                   led
);

  localparam int TW = timer_w(INIT_CYC, TXDIS_CYC);
  localparam int RW = cnt_w(MAX_RETRIES + 1);
  localparam int LW = cnt_w(LED_HALF_CYC);

  for (genvar i = 0; i < NUM_SFP; i++) begin : g_port
    logic          rx_f, flt_f;
    logic          txdis, lup, flat;
    chan_state_e   st;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;

    sfp_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_rx (
      .clk(clk), .rst_n(resetn), .din(sfp_rx_loss[i]), .dout(rx_f));
    sfp_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_flt (
      .clk(clk), .rst_n(resetn), .din(sfp_tx_fault[i]), .dout(flt_f));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        st    <= ST_DISABLED;
        timer <= '0;
        retry <= '0;
        txdis <= 1'b1;
        lup   <= 1'b0;
        flat  <= 1'b0;
      end else begin
        case (st)
          ST_DISABLED: begin
            retry <= '0;
            if (enable[i]) begin
              st    <= ST_INIT;
              timer <= TW'(INIT_CYC - 1);
              txdis <= 1'b0;
            end
          end
          // INIT and ACTIVE share the disable and fault priority chain.
          ST_INIT, ST_ACTIVE: begin
            if (!enable[i]) begin
              st    <= ST_DISABLED;
              retry <= '0;
              txdis <= 1'b1;
              lup   <= 1'b0;
            end else if (flt_f) begin
              txdis <= 1'b1;
              lup   <= 1'b0;
              if (retry < RW'(MAX_RETRIES)) begin
                st    <= ST_RECOVER;
                retry <= retry + 1'b1;
                timer <= TW'(TXDIS_CYC - 1);
              end else begin
                st   <= ST_LATCHED;
                flat <= 1'b1;
              end
            end else if (st == ST_ACTIVE)
              lup <= ~rx_f;
            else if (timer == '0) begin
              st  <= ST_ACTIVE;
              lup <= ~rx_f;
            end else
              timer <= timer - 1'b1;
          end
          ST_RECOVER: begin
            if (!enable[i]) begin
              st    <= ST_DISABLED;
              retry <= '0;
            end else if (timer == '0) begin
              st    <= ST_INIT;
              timer <= TW'(INIT_CYC - 1);
              txdis <= 1'b0;
            end else
              timer <= timer - 1'b1;
          end
          ST_LATCHED: begin
            if (clear_fault[i]) begin
              st    <= ST_DISABLED;
              retry <= '0;
              flat  <= 1'b0;
            end
          end
          default: begin
            st    <= ST_DISABLED;
            txdis <= 1'b1;
            lup   <= 1'b0;
            flat  <= 1'b0;
          end
        endcase
      end
    end

    assign sfp_tx_disable[i]  = txdis;
    assign link_up[i]         = lup;
    assign fault_latched[i]   = flat;
    assign chan_state[3*i +: 3] = st;
  end

  logic [NUM_SFP-1:0] lup_d, flat_d;
  logic [LW-1:0]      led_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq     <= 1'b0;
      led     <= 1'b0;
      lup_d   <= '0;
      flat_d  <= '0;
      led_cnt <= '0;
    end else begin
      irq    <= |((link_up ^ lup_d) | (fault_latched & ~flat_d));
      lup_d  <= link_up;
      flat_d <= fault_latched;
      // Blink counter only runs while a fault is latched.
      if (|fault_latched) begin
        if (led_cnt == LW'(LED_HALF_CYC - 1)) begin
          led_cnt <= '0;
          led     <= ~led;
        end else
          led_cnt <= led_cnt + 1'b1;
      end else begin
        led_cnt <= '0;
        led     <= (|enable) & (&(link_up | ~enable));
      end
    end
  end

endmodule

// File: tb/tb_sfp_cage_ctrl.sv
// Vector-table bench for sfp_cage_ctrl with a small expected-result queue.
module tb_sfp_cage_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] sfp_rx_loss, sfp_tx_fault, sfp_tx_disable;
  logic [1:0] enable, clear_fault, link_up, fault_latched;
  logic [5:0] chan_state;
  logic       irq, led;

  sfp_cage_ctrl #(
    .NUM_SFP(2), .DEBOUNCE_CYC(4), .INIT_CYC(10), .TXDIS_CYC(5),
    .MAX_RETRIES(2), .LED_HALF_CYC(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .sfp_rx_loss(sfp_rx_loss), .sfp_tx_fault(sfp_tx_fault),
    .sfp_tx_disable(sfp_tx_disable), .enable(enable),
    .clear_fault(clear_fault), .link_up(link_up),
    .fault_latched(fault_latched), .chan_state(chan_state),
    .irq(irq), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] en, rx, flt, clr;
    logic [1:0] txdis;
    int         st0, st1;
    logic [1:0] lup, flat;
    logic       led;
    int         irq;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    //             cyc en    rx    flt   clr   txdis st0 st1 lup   flat  led irq
    vt.push_back('{50, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 0, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{9,  2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2, 0, 2'd1, 2'd0, 0, 0});
    vt.push_back('{2,  2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2, 0, 2'd1, 2'd0, 1, 1});
    vt.push_back('{3,  2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2, 0, 2'd1, 2'd0, 1, 0});
    vt.push_back('{10, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2, 0, 2'd1, 2'd0, 1, 0});
    vt.push_back('{6,  2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2, 0, 2'd1, 2'd0, 1, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2, 0, 2'd0, 2'd0, 1, 0});
    vt.push_back('{2,  2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2, 0, 2'd0, 2'd0, 0, 1});
    vt.push_back('{6,  2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 3, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{4,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 3, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 3, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{4,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 3, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 0, 1});
    vt.push_back('{6,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 0, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 1, 0});
    vt.push_back('{7,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 1, 0});
    vt.push_back('{1,  2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 4, 0, 2'd0, 2'd1, 0, 0});
    // fault removed, port 1 enabled; port 0 stays latched
    vt.push_back('{8,  2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 4, 1, 2'd0, 2'd1, 1, 0});
    // clear both: port 0 leaves LATCHED, port 1 (INIT) ignores it
    vt.push_back('{1,  2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 0, 1, 2'd0, 2'd0, 1, 0});
    vt.push_back('{1,  2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 1, 1, 2'd0, 2'd0, 0, 0});
    vt.push_back('{1,  2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 1, 2, 2'd2, 2'd0, 0, 0});
    // retry count was cleared: a fresh fault recovers rather than latching
    vt.push_back('{6,  2'd3, 2'd1, 2'd1, 2'd0, 2'd0, 1, 2, 2'd2, 2'd0, 0, 1});
    vt.push_back('{1,  2'd3, 2'd1, 2'd1, 2'd0, 2'd1, 3, 2, 2'd2, 2'd0, 0, 0});

    enable = '0; clear_fault = '0; sfp_rx_loss = '0; sfp_tx_fault = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst txdis", sfp_tx_disable, 2'b11);
    chk("rst state", chan_state, 6'd0);
    chk("rst link", link_up, 2'b00);
    chk("rst flat", fault_latched, 2'b00);
    chk("rst irq", irq, 1'b0);
    chk("rst led", led, 1'b0);
    resetn = 1'b1;

    foreach (vt[k]) begin
      vec_t v, e;
      int   n;
      v = vt[k];
      enable = v.en; sfp_rx_loss = v.rx; sfp_tx_fault = v.flt; clear_fault = v.clr;
      sb.push_back(v);
      n = 0;
      repeat (v.cyc) begin
        @(posedge clk);
        @(negedge clk);
        if (irq === 1'b1) n++;
      end
      e = sb.pop_front();
      chk($sformatf("v%0d txdis", k), sfp_tx_disable, e.txdis);
      chk($sformatf("v%0d st0", k), chan_state[2:0], e.st0);
      chk($sformatf("v%0d st1", k), chan_state[5:3], e.st1);
      chk($sformatf("v%0d link", k), link_up, e.lup);
      chk($sformatf("v%0d flat", k), fault_latched, e.flat);
      chk($sformatf("v%0d led", k), led, e.led);
      chk($sformatf("v%0d irqcnt", k), n, e.irq);
    end

    // Port 0 is mid-RECOVER here: reset must act without a clock edge.
    resetn = 1'b0;
    #1;
    chk("async txdis", sfp_tx_disable, 2'b11);
    chk("async state", chan_state, 6'd0);
    chk("async link", link_up, 2'b00);
    chk("async flat", fault_latched, 2'b00);
    chk("async led", led, 1'b0);
    chk("async irq", irq, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
